// File: rtl/mac_pkg.sv
// Shared types and constants for the product accumulator: state encoding,
// default widths, accumulator width derivation and signed product limits.
package mac_pkg;

    localparam int MAC_PROD_W  = 64;
    localparam int MAC_GUARD_W = 8;
    localparam int MAC_LEN_W   = 8;

    function automatic int acc_width(input int prod_w, input int guard_w);
        return prod_w + guard_w;
    endfunction

    localparam int MAC_ACC_W = acc_width(MAC_PROD_W, MAC_GUARD_W);

    localparam logic signed [MAC_PROD_W-1:0] PROD_MAX = {1'b0, {(MAC_PROD_W-1){1'b1}}};
    localparam logic signed [MAC_PROD_W-1:0] PROD_MIN = {1'b1, {(MAC_PROD_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mult_accumulator_sat_clamp.sv
// Signed saturation of the guarded accumulator down to the product width.
// Only compiled when MAC_SATURATE_EN is defined; the wrap build has no clamp.
`ifdef MAC_SATURATE_EN
module sat_clamp
    import mac_pkg::*;
#(
    parameter int ACC_W  = MAC_ACC_W,
    parameter int PROD_W = MAC_PROD_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [PROD_W-1:0] result_o,
    output logic              overflow_o
);

    localparam logic [PROD_W-1:0] MAX_V = {1'b0, {(PROD_W-1){1'b1}}};
    localparam logic [PROD_W-1:0] MIN_V = {1'b1, {(PROD_W-1){1'b0}}};

    // The value fits when the guard bits and the product sign bit all agree.
    logic [ACC_W-PROD_W:0] top_bits;
    logic                  fits;

    assign top_bits = acc_i[ACC_W-1:PROD_W-1];
    assign fits     = (&top_bits) | ~(|top_bits);

    always_comb begin
        overflow_o = ~fits;
        if (fits) begin
            result_o = acc_i[PROD_W-1:0];
        end else if (acc_i[ACC_W-1]) begin
            result_o = MIN_V;
        end else begin
            result_o = MAX_V;
        end
    end

endmodule
`endif

// File: rtl/mult_accumulator.sv
// Accumulates a programmed number of signed products and hands out one sum per
// run over a valid/ready handshake. MAC_SATURATE_EN selects clamped output.
module mult_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W  = MAC_PROD_W,
    parameter int GUARD_W = MAC_GUARD_W,
    parameter int LEN_W   = MAC_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [PROD_W-1:0] product_i,
    input  logic              product_valid,
    output logic              product_ready,
    output logic              busy,
    output logic [PROD_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overflow
);

    localparam int ACC_W = acc_width(PROD_W, GUARD_W);

    mac_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             busy_q, busy_d;
    logic             product_ready_q, product_ready_d;
    logic             result_valid_q, result_valid_d;

    logic take;
    logic last;

    assign take = product_valid & product_ready_q;
    assign last = (count_q == len_q - LEN_W'(1));

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        count_d         = count_q;
        len_d           = len_q;
        busy_d          = busy_q;
        product_ready_d = product_ready_q;
        result_valid_d  = result_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len_i;
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    if (len_i != '0) begin
                        state_d         = ACCUM;
                        product_ready_d = 1'b1;
                    end else begin
                        state_d        = DONE;
                        result_valid_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (take) begin
                    acc_d   = acc_q + {{GUARD_W{product_i[PROD_W-1]}}, product_i};
                    count_d = count_q + LEN_W'(1);
                    if (last) begin
                        state_d         = DONE;
                        product_ready_d = 1'b0;
                        result_valid_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d        = IDLE;
                    busy_d         = 1'b0;
                    result_valid_d = 1'b0;
                end
            end
            default: begin
                state_d         = IDLE;
                busy_d          = 1'b0;
                product_ready_d = 1'b0;
                result_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            count_q         <= '0;
            len_q           <= '0;
            busy_q          <= 1'b0;
            product_ready_q <= 1'b0;
            result_valid_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            count_q         <= count_d;
            len_q           <= len_d;
            busy_q          <= busy_d;
            product_ready_q <= product_ready_d;
            result_valid_q  <= result_valid_d;
        end
    end

    assign busy          = busy_q;
    assign product_ready = product_ready_q;
    assign result_valid  = result_valid_q;

`ifdef MAC_SATURATE_EN
    sat_clamp #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_clamp (
        .acc_i      (acc_q),
        .result_o   (result),
        .overflow_o (overflow)
    );
`else
    // Guard bits only matter for saturation; the wrap build drops them.
    logic unused_guard;
    assign unused_guard = ^acc_q[ACC_W-1:PROD_W];
    assign result       = acc_q[PROD_W-1:0];
    assign overflow     = 1'b0;
`endif

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Downstream consumer of the signed 32x32 sequential multiplier's 64-bit product. It accumulates a programmed number of signed products into a guarded accumulator and presents one 64-bit sum per accumulation over a valid/ready result handshake. It sits between the multiplier and the result/writeback logic, turning a stream of products into dot-product-style sums.

## Interface
- PROD_W, 64, width of incoming signed product and of result
- GUARD_W, 8, extra accumulator guard bits; accumulator width ACC_W = PROD_W + GUARD_W
- LEN_W, 8, width of term-count input
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin accumulation; honoured only in IDLE
- len_i  input  LEN_W  number of products to accumulate, sampled on accepted start
- product_i  input  PROD_W  signed product from multiplier
- product_valid  input  1  product_i valid
- product_ready  output  1  block accepts product this cycle
- busy  output  1  state != IDLE
- result  output  PROD_W  signed accumulated sum
- result_valid  output  1  result available
- result_ready  input  1  consumer takes result
- overflow  output  1  sum exceeded signed PROD_W range (SATURATE build only)

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: product_ready=0, result_valid=0. On start: latch len_i, acc<=0, count<=0; next state ACCUM if len_i!=0, else DONE (result 0, no products consumed).
- ACCUM: product_ready=1. Each handshake (product_valid & product_ready): acc <= acc + sign-extend(product_i) to ACC_W, count++. Handshake with count==len-1 → DONE. Cycles without product_valid: no change.
- DONE: result_valid=1, product_ready=0; result/overflow derived from acc, stable while held. On result_ready → IDLE.
- start outside IDLE ignored; product_valid in IDLE/DONE ignored (not consumed).
- Arithmetic: two's complement, ACC_W bits, accumulator never wraps for len < 2^GUARD_W.

## Timing
- Reset (reset=0, any state, async): state IDLE, acc=0, count=0, product_ready=0, busy=0, result_valid=0, result=0, overflow=0.
- start accepted in cycle N → busy=1 and product_ready=1 from N+1.
- Last product accepted in cycle M → result_valid=1 from M+1.
- len_i=0: start in N → result_valid=1 in N+1.
- result_ready in DONE cycle K → IDLE in K+1; earliest new start accepted in K+1 (one bubble).
- result_ready and start both high in DONE: handshake completes, start dropped.
- result held indefinitely under backpressure; no products consumed meanwhile.

## Configuration
- MAC_SATURATE_EN defined: result = acc clamped to [-2^(PROD_W-1), 2^(PROD_W-1)-1]; overflow=1 when clamping occurred, valid with result_valid.
- Undefined: result = acc[PROD_W-1:0] (wrap), overflow tied 0, clamp logic absent.

## Structure
- Package mac_pkg: state enum (IDLE/ACCUM/DONE), ACC_W derivation, signed min/max constants for PROD_W.
- One sub-module: sat_clamp (ACC_W in, PROD_W out plus overflow flag), instantiated only under MAC_SATURATE_EN.

## Test plan
- Reset asserted mid-ACCUM after 2 of 4 products → immediately all outputs 0, busy=0; later start works normally.
- len=3, products 464960160, -143362716, 67081 → result 321664525, overflow 0, result_valid one cycle after third handshake.
- len=0 start → result_valid next cycle, result 0, product_ready never asserted.
- len=2, products 0x7FFFFFFFFFFFFFFF twice → with MAC_SATURATE_EN result 0x7FFFFFFFFFFFFFFF, overflow 1; without, result 0xFFFFFFFFFFFFFFFE, overflow 0.
- len=255, product -1 with product_valid toggling every other cycle → exactly 255 handshakes counted, result -255.
- DONE with result_ready low 5 cycles, start pulsed and product_valid high → result stable, start ignored, no product consumed; result_ready high → IDLE next cycle.
